// File: rtl/ppu_scanline_buffer.sv
// Line-doubling ping-pong scanline buffer between the PPU and the HDMI output stage.
// Optional macro SCANLINES_EN halves each RGB555 channel on odd output lines.
module ppu_scanline_buffer #(
  parameter int H_OFFSET   = 64,
  parameter int V_ACTIVE   = 480,
  parameter int UNDERRUN_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ppu_ce,
  input  logic [14:0]           ppu_pixel,
  input  logic [8:0]            ppu_x,
  input  logic [8:0]            ppu_y,
  input  logic [9:0]            next_pixel_x,
  input  logic [9:0]            vga_vcounter,
  output logic [14:0]           pixel,
  output logic                  border,
  output logic                  sync,
  output logic [UNDERRUN_W-1:0] underrun_count
);

  localparam logic [10:0] H_LO   = 11'(H_OFFSET);
  localparam logic [10:0] H_HI   = 11'(H_OFFSET + 512);
  localparam logic [9:0]  H_OFF  = 10'(H_OFFSET);
  localparam logic [10:0] V_LIM  = 11'(V_ACTIVE);

  logic [14:0] mem [0:511];

  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [8:0]  line;
  logic [7:0]  col;
  logic [8:0]  rd_addr;
  logic        v_active;
  logic        rd_active;
  logic        underrun_hit;
  logic [14:0] rd_q;
  logic        active_q;

  always_comb begin
    wr_en        = !reset && ppu_ce && !ppu_x[8] && (ppu_y < 9'd240);
    wr_addr      = {ppu_y[0], ppu_x[7:0]};
    line         = vga_vcounter[9:1];
    // Each stored pixel feeds two adjacent output columns.
    col          = 8'((next_pixel_x - H_OFF) >> 1);
    rd_addr      = {line[0], col};
    v_active     = {1'b0, vga_vcounter} < V_LIM;
    rd_active    = ({1'b0, next_pixel_x} >= H_LO) && ({1'b0, next_pixel_x} < H_HI) && v_active;
    underrun_hit = (next_pixel_x == H_OFF) && v_active && (line == ppu_y);
  end

  // Memory is never reset; the registered read sees the pre-write word on a collision.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= ppu_pixel;
    rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q       <= 1'b0;
      sync           <= 1'b0;
      underrun_count <= '0;
    end else begin
      active_q <= rd_active;
      sync     <= wr_en && (ppu_x == 9'd0) && (ppu_y == 9'd0);
      if (underrun_hit && (underrun_count != '1))
        underrun_count <= underrun_count + 1'b1;
    end
  end

`ifdef SCANLINES_EN
  logic odd_q;

  always_ff @(posedge clk) begin
    if (reset) odd_q <= 1'b0;
    else       odd_q <= vga_vcounter[0];
  end

  always_comb begin
    pixel  = '0;
    border = !active_q;
    if (active_q) begin
      if (odd_q) pixel = {1'b0, rd_q[14:11], 1'b0, rd_q[9:6], 1'b0, rd_q[4:1]};
      else       pixel = rd_q;
    end
  end
`else
  always_comb begin
    pixel  = '0;
    border = !active_q;
    if (active_q) pixel = rd_q;
  end
`endif

endmodule

// File: tb/tb_ppu_scanline_buffer.sv
// Scoreboard bench for ppu_scanline_buffer: boundary table plus multi-cycle sequences.
module tb_ppu_scanline_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ppu_ce;
  logic [14:0] ppu_pixel;
  logic [8:0]  ppu_x;
  logic [8:0]  ppu_y;
  logic [9:0]  next_pixel_x;
  logic [9:0]  vga_vcounter;
  logic [14:0] pixel;
  logic        border;
  logic        sync;
  logic [7:0]  underrun_count;

  ppu_scanline_buffer #(.H_OFFSET(64), .V_ACTIVE(480), .UNDERRUN_W(8)) dut (
    .clk(clk), .reset(reset), .ppu_ce(ppu_ce), .ppu_pixel(ppu_pixel),
    .ppu_x(ppu_x), .ppu_y(ppu_y), .next_pixel_x(next_pixel_x),
    .vga_vcounter(vga_vcounter), .pixel(pixel), .border(border),
    .sync(sync), .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic [14:0] pix;
    logic        border;
    logic        sync;
    logic [7:0]  under;
  } exp_t;

  typedef struct {
    logic [9:0]  npx;
    logic [9:0]  vc;
    logic [14:0] pix;
    logic        border;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] m_under = 8'd0;

  function automatic logic [14:0] sl(input logic [14:0] v, input logic odd);
`ifdef SCANLINES_EN
    if (odd) return {1'b0, v[14:11], 1'b0, v[9:6], 1'b0, v[4:1]};
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: record what the current inputs should produce, then compare after the edge.
  task automatic tick(input logic chk_pix, input logic [14:0] ep, input logic eb);
    exp_t e;
    e.chk    = chk_pix;
    e.pix    = ep;
    e.border = eb;
    e.sync   = !reset && ppu_ce && (ppu_x == 9'd0) && (ppu_y == 9'd0);
    if (!reset && next_pixel_x == 10'd64 && vga_vcounter < 10'd480 &&
        vga_vcounter[9:1] == ppu_y && m_under != 8'hFF)
      m_under++;
    if (reset) begin
      m_under  = 8'd0;
      e.chk    = 1'b1;
      e.pix    = 15'd0;
      e.border = 1'b1;
    end
    e.under = m_under;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.chk) check("pixel", 32'(pixel), 32'(e.pix));
    check("border", 32'(border), 32'(e.border));
    check("sync", 32'(sync), 32'(e.sync));
    check("underrun", 32'(underrun_count), 32'(e.under));
  endtask

  task automatic rd(input logic [9:0] npx, input logic [9:0] vc, input logic chk,
                    input logic [14:0] ep, input logic eb);
    next_pixel_x = npx;
    vga_vcounter = vc;
    tick(chk, ep, eb);
  endtask

  task automatic wr(input logic [8:0] x, input logic [8:0] y, input logic [14:0] d);
    ppu_ce       = 1'b1;
    ppu_x        = x;
    ppu_y        = y;
    ppu_pixel    = d;
    next_pixel_x = 10'd0;
    vga_vcounter = 10'd0;
    tick(1'b1, 15'd0, 1'b1);
    ppu_ce = 1'b0;
    ppu_y  = 9'd300;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    logic [14:0] ev;
    vecs[0]  = '{10'd64,  10'd8,   15'd0,   1'b0};
    vecs[1]  = '{10'd65,  10'd9,   15'd0,   1'b0};
    vecs[2]  = '{10'd66,  10'd8,   15'd1,   1'b0};
    vecs[3]  = '{10'd200, 10'd8,   15'd68,  1'b0};
    vecs[4]  = '{10'd575, 10'd8,   15'd255, 1'b0};
    vecs[5]  = '{10'd574, 10'd9,   15'd255, 1'b0};
    vecs[6]  = '{10'd63,  10'd8,   15'd0,   1'b1};
    vecs[7]  = '{10'd576, 10'd9,   15'd0,   1'b1};
    vecs[8]  = '{10'd0,   10'd8,   15'd0,   1'b1};
    vecs[9]  = '{10'd639, 10'd8,   15'd0,   1'b1};
    vecs[10] = '{10'd64,  10'd480, 15'd0,   1'b1};
    vecs[11] = '{10'd300, 10'd600, 15'd0,   1'b1};

    reset = 1'b1; ppu_ce = 1'b0; ppu_pixel = '0; ppu_x = '0; ppu_y = 9'd300;
    next_pixel_x = '0; vga_vcounter = '0;
    repeat (3) tick(1'b1, 15'd0, 1'b1);
    reset = 1'b0;
    tick(1'b1, 15'd0, 1'b1);

    // Fill line 4 with pixel = column.
    for (int x = 0; x < 256; x++) wr(9'(x), 9'd4, 15'(x));

    // Full sweep of output lines 8 and 9 (both source line 4).
    for (int v = 8; v <= 9; v++) begin
      for (int x = 0; x < 640; x++) begin
        if (x >= 64 && x < 576) rd(10'(x), 10'(v), 1'b1, sl(15'((x - 64) >> 1), v[0]), 1'b0);
        else                    rd(10'(x), 10'(v), 1'b1, 15'd0, 1'b1);
      end
    end

    for (int i = 0; i < 12; i++) begin
      ev = vecs[i].border ? vecs[i].pix : sl(vecs[i].pix, vecs[i].vc[0]);
      rd(vecs[i].npx, vecs[i].vc, 1'b1, ev, vecs[i].border);
    end

    // Frame-start pulse, then the same coordinates without the strobe.
    wr(9'd0, 9'd0, 15'd0);
    rd(10'd0, 10'd0, 1'b1, 15'd0, 1'b1);
    check("sync_low_after", 32'(sync), 32'd0);
    ppu_x = 9'd0; ppu_y = 9'd0; ppu_ce = 1'b0;
    rd(10'd0, 10'd0, 1'b1, 15'd0, 1'b1);
    rd(10'd0, 10'd0, 1'b1, 15'd0, 1'b1);
    ppu_y = 9'd300;

    // Underrun: PPU still on line 10 while line 10 is displayed.
    ppu_y = 9'd10;
    rd(10'd64, 10'd20, 1'b0, 15'd0, 1'b0);
    check("underrun_first", 32'(underrun_count), 32'd1);
    repeat (299) rd(10'd64, 10'd20, 1'b0, 15'd0, 1'b0);
    check("underrun_sat", 32'(underrun_count), 32'hFF);
    ppu_y = 9'd300;

    // Same-cycle read and write of bank 0, address 5.
    wr(9'd5, 9'd0, 15'h1234);
    ppu_ce = 1'b1; ppu_x = 9'd5; ppu_y = 9'd0; ppu_pixel = 15'h7FFF;
    rd(10'd74, 10'd0, 1'b1, 15'h1234, 1'b0);
    ppu_ce = 1'b0; ppu_y = 9'd300;
    rd(10'd74, 10'd0, 1'b1, 15'h7FFF, 1'b0);

    // Odd/even line shading of a full-white pixel.
    wr(9'd10, 9'd4, 15'h7FFF);
    rd(10'd84, 10'd9, 1'b1, sl(15'h7FFF, 1'b1), 1'b0);
    rd(10'd84, 10'd8, 1'b1, 15'h7FFF, 1'b0);

    // Mid-line reset with a write strobe present: outputs reset, write dropped.
    wr(9'd7, 9'd0, 15'h1111);
    reset = 1'b1; ppu_ce = 1'b1; ppu_x = 9'd7; ppu_y = 9'd0; ppu_pixel = 15'h2222;
    rd(10'd78, 10'd0, 1'b1, 15'd0, 1'b1);
    reset = 1'b0; ppu_ce = 1'b0; ppu_y = 9'd300;
    rd(10'd78, 10'd0, 1'b1, 15'h1111, 1'b0);
    rd(10'd0, 10'd0, 1'b1, 15'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
